// File: rtl/superh16_pkg.sv
// Shared types and constants for the SuperH16 instruction fetch queue.
// A queue entry holds one 64-byte I-cache line plus the aligned line base
// address and the word offset where decode resumes within that line.
package superh16_pkg;

  localparam int VADDR_WIDTH          = 32;
  localparam int FETCH_LINE_BYTES     = 64;
  localparam int FETCH_WORDS_PER_LINE = 16;

  typedef struct packed {
    logic [511:0]             data;
    logic [VADDR_WIDTH-1:0]   base;
    logic [3:0]               offset;
  } fq_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [VADDR_WIDTH-1:0]   pc;
  } fq_track_t;

endpackage

// File: rtl/superh16_fq_inflight.sv
// Two-stage tracker of I-cache requests in flight. A request enters stage 0
// when issued and reaches stage 1 in the cycle its response returns, so
// stage 1 always describes the response currently on the bus.
// A miss kills the younger sequential fetch; a flush empties both stages but
// still captures a request issued in the flush cycle (it belongs to the new path).
module superh16_fq_inflight
  import superh16_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   load,
  input  logic [VADDR_WIDTH-1:0] load_pc,
  input  logic                   kill,
  output logic                   match_valid,
  output logic [VADDR_WIDTH-1:0] match_pc,
  output logic [1:0]             inflight_count
);

  fq_track_t stage0;
  fq_track_t stage1;

  // Shift the tracker each cycle; flush and miss-kill override the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage0 <= '0;
      stage1 <= '0;
    end else if (flush) begin
      stage1 <= '0;
      stage0 <= '{valid: load, pc: load_pc};
    end else if (kill) begin
      stage1 <= '0;
      stage0 <= '0;
    end else begin
      stage1 <= stage0;
      stage0 <= '{valid: load, pc: load_pc};
    end
  end

  assign match_valid    = stage1.valid;
  assign match_pc       = stage1.pc;
  assign inflight_count = {1'b0, stage0.valid} + {1'b0, stage1.valid};

endmodule

// File: rtl/superh16_fetch_queue.sv
// SuperH16 fetch queue: captures I-cache line responses into a small circular
// buffer and presents up to ISSUE_WIDTH aligned 32-bit instructions per cycle
// to decode, never crossing a line boundary within one group.
// Optional performance counters are built when SUPERH16_FQ_PERF_EN is defined.
module superh16_fetch_queue
  import superh16_pkg::*;
#(
  parameter int FQ_DEPTH    = 4,
  parameter int ISSUE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [VADDR_WIDTH-1:0]    req_pc,
  output logic                      fq_ready,
  input  logic                      resp_valid,
  input  logic [511:0]              resp_data,
  input  logic                      resp_miss,
  output logic [ISSUE_WIDTH-1:0]    dec_valid,
  output logic [ISSUE_WIDTH*32-1:0] dec_instr,
  output logic [VADDR_WIDTH-1:0]    dec_pc,
  input  logic                      dec_ready,
  output logic                      miss_valid,
  output logic [VADDR_WIDTH-1:0]    miss_pc,
  output logic                      overflow_err
`ifdef SUPERH16_FQ_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_miss_count
`endif
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  fq_entry_t                mem [FQ_DEPTH];
  fq_entry_t                head;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [SUM_W-1:0]         pending;

  logic                     match_valid;
  logic [VADDR_WIDTH-1:0]   match_pc;
  logic [1:0]               inflight_count;

  logic                     tracked_resp;
  logic                     push_req;
  logic                     push_ok;
  logic                     kill;
  logic                     full;
  logic                     empty;
  logic                     consume;
  logic                     pop;
  logic [4:0]               head_room;
  logic [4:0]               slot_count;
  logic [4:0]               next_offset;
  logic [4:0]               word_idx;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  superh16_fq_inflight u_inflight (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .load           (req_valid),
    .load_pc        (req_pc),
    .kill           (kill),
    .match_valid    (match_valid),
    .match_pc       (match_pc),
    .inflight_count (inflight_count)
  );

  assign tracked_resp = resp_valid && match_valid;
  assign push_req     = tracked_resp && !resp_miss && !flush;
  assign kill         = tracked_resp && resp_miss && !flush;
  assign full         = (count == CNT_W'(FQ_DEPTH));
  assign empty        = (count == '0);
  assign push_ok      = push_req && !full;

  // Upstream may only issue when every in-flight request is guaranteed a slot.
  assign pending  = SUM_W'(count) + SUM_W'(inflight_count);
  assign fq_ready = (pending < SUM_W'(FQ_DEPTH));

  assign head        = mem[rd_ptr];
  assign head_room   = 5'd16 - {1'b0, head.offset};
  assign slot_count  = (head_room < 5'(ISSUE_WIDTH)) ? head_room : 5'(ISSUE_WIDTH);
  assign next_offset = {1'b0, head.offset} + slot_count;
  assign consume     = dec_ready && dec_valid[0] && !flush;
  assign pop         = consume && next_offset[4];

  // Pointer, occupancy, miss-report and overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      miss_valid   <= 1'b0;
      miss_pc      <= '0;
      overflow_err <= 1'b0;
    end else begin
      miss_valid <= kill;
      if (kill) begin
        miss_pc <= match_pc;
      end
      if (push_req && full) begin
        overflow_err <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= ptr_next(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_next(rd_ptr);
        end
        if (push_ok && !pop) begin
          count <= count + 1'b1;
        end else if (!push_ok && pop) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Line storage: write new lines at the tail, advance the head's word offset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{data:   resp_data,
                       base:   {match_pc[VADDR_WIDTH-1:6], 6'b0},
                       offset: match_pc[5:2]};
    end
    if (consume && !pop) begin
      mem[rd_ptr].offset <= next_offset[3:0];
    end
  end

  // Select the decode group from the head line, stopping at the line end.
  always_comb begin
    dec_valid = '0;
    dec_instr = '0;
    word_idx  = '0;
    dec_pc    = empty ? '0 : head.base + VADDR_WIDTH'({head.offset, 2'b00});
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      word_idx = 5'(k) + {1'b0, head.offset};
      if (!empty && !word_idx[4]) begin
        dec_valid[k]          = 1'b1;
        dec_instr[32*k +: 32] = head.data[{word_idx[3:0], 5'b0} +: 32];
      end
    end
  end

`ifdef SUPERH16_FQ_PERF_EN
  // Saturating stall and miss counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_miss_count   <= '0;
    end else begin
      if (dec_valid[0] && !dec_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      end
      if (miss_valid && (perf_miss_count != '1)) begin
        perf_miss_count <= perf_miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_superh16_fetch_queue.sv
// Directed self-checking bench for superh16_fetch_queue (default parameters).
// Inputs change and outputs are sampled 2 time units after each rising edge.
// Line data is synthesised so that every word identifies its line and index.
module tb_superh16_fetch_queue;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         req_valid;
  logic [31:0]  req_pc;
  logic         fq_ready;
  logic         resp_valid;
  logic [511:0] resp_data;
  logic         resp_miss;
  logic [3:0]   dec_valid;
  logic [127:0] dec_instr;
  logic [31:0]  dec_pc;
  logic         dec_ready;
  logic         miss_valid;
  logic [31:0]  miss_pc;
  logic         overflow_err;
`ifdef SUPERH16_FQ_PERF_EN
  logic [31:0]  perf_stall_cycles;
  logic [31:0]  perf_miss_count;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  superh16_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .fq_ready     (fq_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_miss    (resp_miss),
    .dec_valid    (dec_valid),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_ready    (dec_ready),
    .miss_valid   (miss_valid),
    .miss_pc      (miss_pc),
    .overflow_err (overflow_err)
`ifdef SUPERH16_FQ_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_miss_count   (perf_miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] wordOf(input logic [31:0] base, input int w);
    return {base[23:0], 8'(w)};
  endfunction

  function automatic logic [511:0] lineOf(input logic [31:0] base);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = wordOf(base, w);
    return l;
  endfunction

  function automatic logic [127:0] groupOf(input logic [31:0] base, input int off);
    logic [127:0] g;
    for (int k = 0; k < 4; k++) g[32*k +: 32] = wordOf(base, off + k);
    return g;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One cycle of upstream activity; all pulsed inputs return to idle afterwards.
  task automatic applyStimulus(input logic rv, input logic [31:0] pc,
                               input logic sv, input logic sm,
                               input logic [511:0] sd, input logic fl);
    req_valid  = rv;
    req_pc     = pc;
    resp_valid = sv;
    resp_miss  = sm;
    resp_data  = sd;
    flush      = fl;
    @(posedge clk);
    #2;
    req_valid  = 1'b0;
    req_pc     = '0;
    resp_valid = 1'b0;
    resp_miss  = 1'b0;
    resp_data  = '0;
    flush      = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic doFetch(input logic [31:0] pc, input logic miss);
    applyStimulus(1'b1, pc, 1'b0, 1'b0, '0, 1'b0);
    idle();
    applyStimulus(1'b0, 32'h0, 1'b1, miss, lineOf({pc[31:6], 6'b0}), 1'b0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    flush = 0; req_valid = 0; req_pc = 0; resp_valid = 0;
    resp_data = '0; resp_miss = 0; dec_ready = 0;
    applyReset();

    // Reset state
    checkOutput("rst_dec_valid", 128'(dec_valid), 128'h0);
    checkOutput("rst_fq_ready", 128'(fq_ready), 128'h1);
    checkOutput("rst_miss_valid", 128'(miss_valid), 128'h0);
    checkOutput("rst_overflow", 128'(overflow_err), 128'h0);

    // Aligned line drained in four full groups
    doFetch(32'h1000, 1'b0);
    checkOutput("t1_valid_first", 128'(dec_valid), 128'hf);
    dec_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("t1_pc_%0d", g), 128'(dec_pc), 128'(32'h1000 + 16*g));
      checkOutput($sformatf("t1_instr_%0d", g), dec_instr, groupOf(32'h1000, 4*g));
      checkOutput($sformatf("t1_valid_%0d", g), 128'(dec_valid), 128'hf);
      idle();
    end
    checkOutput("t1_empty", 128'(dec_valid), 128'h0);
    dec_ready = 1'b0;

    // Fetch near line end yields a partial group
    doFetch(32'h2038, 1'b0);
    checkOutput("t2_valid", 128'(dec_valid), 128'h3);
    checkOutput("t2_pc", 128'(dec_pc), 128'h2038);
    checkOutput("t2_instr", 128'(dec_instr[63:0]),
                128'({wordOf(32'h2000, 15), wordOf(32'h2000, 14)}));
    dec_ready = 1'b1;
    idle();
    checkOutput("t2_empty", 128'(dec_valid), 128'h0);
    dec_ready = 1'b0;

    // Miss kills the younger sequential fetch
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h3040, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, '0, 1'b0);
    checkOutput("t3_miss_valid", 128'(miss_valid), 128'h1);
    checkOutput("t3_miss_pc", 128'(miss_pc), 128'h3000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, lineOf(32'h3040), 1'b0);
    checkOutput("t3_miss_pulse_end", 128'(miss_valid), 128'h0);
    idle();
    checkOutput("t3_empty", 128'(dec_valid), 128'h0);
    checkOutput("t3_ready", 128'(fq_ready), 128'h1);

    // Fill to depth, then force an overflow
    applyStimulus(1'b1, 32'h4000, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_ready_a", 128'(fq_ready), 128'h1);
    applyStimulus(1'b1, 32'h4040, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h4080, 1'b1, 1'b0, lineOf(32'h4000), 1'b0);
    checkOutput("t4_ready_b", 128'(fq_ready), 128'h1);
    applyStimulus(1'b1, 32'h40c0, 1'b1, 1'b0, lineOf(32'h4040), 1'b0);
    checkOutput("t4_ready_c", 128'(fq_ready), 128'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, lineOf(32'h4080), 1'b0);
    checkOutput("t4_ready_d", 128'(fq_ready), 128'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, lineOf(32'h40c0), 1'b0);
    checkOutput("t4_ready_full", 128'(fq_ready), 128'h0);
    checkOutput("t4_no_overflow_yet", 128'(overflow_err), 128'h0);
    doFetch(32'h4100, 1'b0);
    checkOutput("t4_overflow", 128'(overflow_err), 128'h1);
    dec_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int g = 0; g < 4; g++) begin
        checkOutput($sformatf("t4_pc_%0d_%0d", l, g), 128'(dec_pc),
                    128'(32'h4000 + 64*l + 16*g));
        checkOutput($sformatf("t4_instr_%0d_%0d", l, g), dec_instr,
                    groupOf(32'h4000 + 64*l, 4*g));
        idle();
      end
    end
    checkOutput("t4_drained", 128'(dec_valid), 128'h0);
    checkOutput("t4_ready_after", 128'(fq_ready), 128'h1);
    dec_ready = 1'b0;

    // Flush with two lines queued and two requests in flight
    doFetch(32'h5000, 1'b0);
    doFetch(32'h5040, 1'b0);
    checkOutput("t5_head_pc", 128'(dec_pc), 128'h5000);
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h6040, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, lineOf(32'h6000), 1'b1);
    checkOutput("t5_flush_valid", 128'(dec_valid), 128'h0);
    checkOutput("t5_flush_ready", 128'(fq_ready), 128'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, lineOf(32'h6040), 1'b0);
    checkOutput("t5_discard", 128'(dec_valid), 128'h0);
    idle();
    checkOutput("t5_still_empty", 128'(dec_valid), 128'h0);
    checkOutput("t5_ready", 128'(fq_ready), 128'h1);
    checkOutput("t5_overflow_sticky", 128'(overflow_err), 128'h1);

    // Reset clears sticky state; then asynchronous reset mid-drain
    applyReset();
    checkOutput("t6_overflow_cleared", 128'(overflow_err), 128'h0);
    doFetch(32'h3000, 1'b1);
    checkOutput("t6_miss_valid", 128'(miss_valid), 128'h1);
    checkOutput("t6_miss_pc", 128'(miss_pc), 128'h3000);
    idle();
    dec_ready = 1'b1;
    doFetch(32'h7000, 1'b0);
    idle();
    idle();
    checkOutput("t6_pc_offset8", 128'(dec_pc), 128'h7020);
    dec_ready = 1'b0;
    for (int s = 0; s < 5; s++) idle();
    checkOutput("t6_pc_stalled", 128'(dec_pc), 128'h7020);
`ifdef SUPERH16_FQ_PERF_EN
    checkOutput("t6_perf_stall", 128'(perf_stall_cycles), 128'd5);
    checkOutput("t6_perf_miss", 128'(perf_miss_count), 128'd1);
`endif
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_dec_valid", 128'(dec_valid), 128'h0);
    checkOutput("t6_rst_miss_valid", 128'(miss_valid), 128'h0);
    checkOutput("t6_rst_miss_pc", 128'(miss_pc), 128'h0);
    checkOutput("t6_rst_overflow", 128'(overflow_err), 128'h0);
`ifdef SUPERH16_FQ_PERF_EN
    checkOutput("t6_rst_perf_stall", 128'(perf_stall_cycles), 128'd0);
    checkOutput("t6_rst_perf_miss", 128'(perf_miss_count), 128'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_ready_after_rst", 128'(fq_ready), 128'h1);
    idle();
    checkOutput("t6_empty_after_rst", 128'(dec_valid), 128'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
